// File: rtl/error_correction_channel_pkg.sv
// Shared definitions for the error-correction channel: frame geometry defaults
// and the per-bit state / frame phase encodings used by former and deformer.
package error_correction_channel_pkg;

  localparam int unsigned         PREAMBLE_LEN_DEF = 30;
  localparam logic [29:0]         PREAMBLE_VAL_DEF = 30'h0123425;
  localparam int unsigned         PAYLOAD_LEN_DEF  = 48;

  typedef enum logic [2:0] {
    ST_WAIT_IN   = 3'd0,
    ST_READ      = 3'd1,
    ST_GET       = 3'd2,
    ST_EVAL      = 3'd3,
    ST_CHECK_OUT = 3'd4,
    ST_SEND      = 3'd5
  } chan_state_e;

  typedef enum logic [1:0] {
    PH_HUNT    = 2'd0,
    PH_PAYLOAD = 2'd1,
    PH_CHECK   = 2'd2
  } chan_phase_e;

endpackage

// File: rtl/preamble_correlator.sv
// Hamming distance between the received window and the expected preamble.
module preamble_correlator #(
  parameter int unsigned LEN    = 30,
  parameter int unsigned DIST_W = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0]    shift_i,
  input  logic [LEN-1:0]    ref_i,
  output logic [DIST_W-1:0] dist_o
);

  logic [LEN-1:0] diff;

  assign diff = shift_i ^ ref_i;

  always_comb begin
    dist_o = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      dist_o = dist_o + DIST_W'(diff[i]);
    end
  end

endmodule

// File: rtl/frame_deformer.sv
// Serial frame deformer: hunts for the preamble, forwards payload bits while
// locked, and flywheels through up to LOCK_MISS-1 corrupted preambles.
module frame_deformer
  import error_correction_channel_pkg::*;
#(
  parameter int unsigned              PREAMBLE_LEN = PREAMBLE_LEN_DEF,
  parameter logic [PREAMBLE_LEN-1:0]  PREAMBLE_VAL = PREAMBLE_LEN'(PREAMBLE_VAL_DEF),
  parameter int unsigned              PAYLOAD_LEN  = PAYLOAD_LEN_DEF,
  parameter int unsigned              MAX_ERR      = 2,
  parameter int unsigned              LOCK_MISS    = 3
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic FIFO_IN_DATA,
  output logic FIFO_IN_RE,
  input  logic FIFO_IN_EMPTY,
  output logic FIFO_OUT_DATA,
  output logic FIFO_OUT_WE,
  input  logic FIFO_OUT_FULL,
  output logic SYNC_LOCK,
  output logic PREAMBLE_MISS
);

  localparam int unsigned DIST_W  = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned FILL_W  = DIST_W;
  localparam int unsigned CNT_MAX = (PAYLOAD_LEN > PREAMBLE_LEN) ? PAYLOAD_LEN : PREAMBLE_LEN;
  localparam int unsigned BIT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned MISS_W  = $clog2(LOCK_MISS + 1);

  chan_state_e             state_q;
  chan_phase_e             phase_q;
  logic [PREAMBLE_LEN-1:0] shift_q;
  logic                    data_q;
  logic [FILL_W-1:0]       fill_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [MISS_W-1:0]       miss_cnt_q;
  logic                    re_q;
  logic                    we_q;
  logic                    odata_q;
  logic                    lock_q;
  logic                    miss_pulse_q;

  logic [DIST_W-1:0]       dist_c;
  logic                    match_c;
  logic [MISS_W-1:0]       miss_inc_c;

  preamble_correlator #(
    .LEN (PREAMBLE_LEN)
  ) u_corr (
    .shift_i (shift_q),
    .ref_i   (PREAMBLE_VAL),
    .dist_o  (dist_c)
  );

  // A match only counts once a full window of real bits has been received.
  assign match_c    = (dist_c <= DIST_W'(MAX_ERR)) && (fill_q >= FILL_W'(PREAMBLE_LEN));
  assign miss_inc_c = miss_cnt_q + MISS_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_WAIT_IN;
      phase_q      <= PH_HUNT;
      shift_q      <= '0;
      data_q       <= 1'b0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      odata_q      <= 1'b0;
      lock_q       <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      miss_pulse_q <= 1'b0;
      case (state_q)
        ST_WAIT_IN: begin
          if (!FIFO_IN_EMPTY) begin
            state_q <= ST_READ;
            re_q    <= 1'b1;
          end
        end
        ST_READ: begin
          state_q <= ST_GET;
          re_q    <= 1'b0;
        end
        ST_GET: begin
          shift_q <= {FIFO_IN_DATA, shift_q[PREAMBLE_LEN-1:1]};
          data_q  <= FIFO_IN_DATA;
          if (fill_q != FILL_W'(PREAMBLE_LEN)) begin
            fill_q <= fill_q + FILL_W'(1);
          end
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          state_q <= ST_WAIT_IN;
          case (phase_q)
            PH_HUNT: begin
              if (match_c) begin
                phase_q    <= PH_PAYLOAD;
                bit_cnt_q  <= '0;
                miss_cnt_q <= '0;
                lock_q     <= 1'b1;
              end
            end
            PH_PAYLOAD: begin
              state_q <= ST_CHECK_OUT;
            end
            PH_CHECK: begin
              if (bit_cnt_q == BIT_W'(PREAMBLE_LEN - 1)) begin
                bit_cnt_q <= '0;
                if (match_c) begin
                  miss_cnt_q <= '0;
                  phase_q    <= PH_PAYLOAD;
                end else begin
                  miss_pulse_q <= 1'b1;
                  if (miss_inc_c == MISS_W'(LOCK_MISS)) begin
                    phase_q    <= PH_HUNT;
                    lock_q     <= 1'b0;
                    miss_cnt_q <= '0;
                  end else begin
                    miss_cnt_q <= miss_inc_c;
                    phase_q    <= PH_PAYLOAD;
                  end
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              end
            end
            default: begin
              phase_q <= PH_HUNT;
              lock_q  <= 1'b0;
            end
          endcase
        end
        ST_CHECK_OUT: begin
          // Held bit stays in data_q for as long as the output is full.
          if (!FIFO_OUT_FULL) begin
            state_q <= ST_SEND;
            we_q    <= 1'b1;
            odata_q <= data_q;
          end
        end
        ST_SEND: begin
          state_q <= ST_WAIT_IN;
          we_q    <= 1'b0;
          odata_q <= 1'b0;
          if (bit_cnt_q == BIT_W'(PAYLOAD_LEN - 1)) begin
            bit_cnt_q <= '0;
            phase_q   <= PH_CHECK;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        default: begin
          state_q <= ST_WAIT_IN;
          phase_q <= PH_HUNT;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
          odata_q <= 1'b0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign FIFO_IN_RE    = re_q;
  assign FIFO_OUT_WE   = we_q;
  assign FIFO_OUT_DATA = odata_q;
  assign SYNC_LOCK     = lock_q;
  assign PREAMBLE_MISS = miss_pulse_q;

endmodule

// File: tb/tb_frame_deformer.sv
// Scoreboard bench for frame_deformer: FIFO models on both sides, expected
// payload bits queued at stimulus time and checked on every output write.
module tb_frame_deformer;

  localparam logic [29:0] PRE      = 30'h0123425;
  localparam logic [29:0] PRE_2ERR = PRE ^ 30'h3;
  localparam logic [29:0] PRE_3ERR = PRE ^ 30'h7;
  localparam logic [47:0] PAY0     = 48'h9C3A_51E7_2B0D;
  localparam logic [47:0] PAY1     = 48'h4F81_D26C_B735;
  localparam logic [47:0] PAY2     = 48'hE05B_7A93_1CF6;
  localparam logic [47:0] PAY3     = 48'h36D2_8E4B_A91F;
  localparam logic [4:0]  LEAD     = 5'b11011;

  logic CLK           = 1'b0;
  logic RESET_N       = 1'b0;
  logic FIFO_IN_DATA  = 1'b0;
  logic FIFO_IN_RE;
  logic FIFO_IN_EMPTY = 1'b1;
  logic FIFO_OUT_DATA;
  logic FIFO_OUT_WE;
  logic FIFO_OUT_FULL = 1'b0;
  logic SYNC_LOCK;
  logic PREAMBLE_MISS;

  bit   in_q[$];
  bit   exp_q[$];
  int   checks       = 0;
  int   errors       = 0;
  int   wr_cnt       = 0;
  int   rd_cnt       = 0;
  int   miss_cnt     = 0;
  int   lock_rise_rd = -1;
  bit   starve       = 1'b0;
  bit   lock_prev    = 1'b0;
  bit   full_prev    = 1'b0;

  frame_deformer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .FIFO_IN_DATA  (FIFO_IN_DATA),
    .FIFO_IN_RE    (FIFO_IN_RE),
    .FIFO_IN_EMPTY (FIFO_IN_EMPTY),
    .FIFO_OUT_DATA (FIFO_OUT_DATA),
    .FIFO_OUT_WE   (FIFO_OUT_WE),
    .FIFO_OUT_FULL (FIFO_OUT_FULL),
    .SYNC_LOCK     (SYNC_LOCK),
    .PREAMBLE_MISS (PREAMBLE_MISS)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    full_prev = FIFO_OUT_FULL;
  end

  // Input FIFO model plus output monitor, both sampled on the falling edge.
  initial forever begin
    @(negedge CLK);
    if (FIFO_IN_RE) begin
      checks++;
      if (FIFO_IN_EMPTY) begin
        errors++;
        $display("FAIL re_while_empty: RE=1 with EMPTY=%0b at %0t, required EMPTY=0", FIFO_IN_EMPTY, $time);
      end
      rd_cnt++;
      FIFO_IN_DATA = (in_q.size() > 0) ? in_q.pop_front() : 1'b0;
    end else begin
      FIFO_IN_EMPTY = (in_q.size() == 0) || (starve && ($urandom_range(0, 1) == 1));
    end
    if (FIFO_OUT_WE) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got write #%0d data=%0b at %0t, required no write", wr_cnt, FIFO_OUT_DATA, $time);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (FIFO_OUT_DATA !== e || full_prev) begin
          errors++;
          $display("FAIL wr_data: write #%0d got data=%0b full_before=%0b, required data=%0b full_before=0", wr_cnt, FIFO_OUT_DATA, full_prev, e);
        end
      end
    end
    if (PREAMBLE_MISS === 1'b1) miss_cnt++;
    if (SYNC_LOCK === 1'b1 && !lock_prev) lock_rise_rd = rd_cnt;
    lock_prev = (SYNC_LOCK === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #2;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_bits(input logic [63:0] v, input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(v[i]);
      if (chk) exp_q.push_back(v[i]);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    in_q.delete();
    FIFO_OUT_FULL = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    lock_rise_rd = -1;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_drained"}, exp_q.size() + in_q.size(), 0);
    tick(12);
  endtask

  task automatic wait_writes(input string name, input int base, input int n);
    int c = 0;
    while ((wr_cnt - base) < n && c < 3000) begin
      tick(1);
      c++;
    end
    check(name, wr_cnt - base, n);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_re"},   int'(FIFO_IN_RE),    0);
    check({name, "_we"},   int'(FIFO_OUT_WE),   0);
    check({name, "_data"}, int'(FIFO_OUT_DATA), 0);
    check({name, "_lock"}, int'(SYNC_LOCK),     0);
    check({name, "_miss"}, int'(PREAMBLE_MISS), 0);
  endtask

  task automatic clean_stream(input string name, input int budget);
    int b_wr, b_rd, b_miss;
    b_wr = wr_cnt; b_rd = rd_cnt; b_miss = miss_cnt;
    push_bits(64'(LEAD), 5, 1'b0);
    push_bits(64'(PRE), 30, 1'b0); push_bits(64'(PAY0), 48, 1'b1);
    push_bits(64'(PRE), 30, 1'b0); push_bits(64'(PAY1), 48, 1'b1);
    push_bits(64'(PRE), 30, 1'b0); push_bits(64'(PAY2), 48, 1'b1);
    wait_drain(name, budget);
    check({name, "_writes"},    wr_cnt - b_wr, 144);
    check({name, "_lock_bit"},  lock_rise_rd - b_rd, 35);
    check({name, "_miss"},      miss_cnt - b_miss, 0);
    check({name, "_lock_end"},  int'(SYNC_LOCK), 1);
  endtask

  initial begin
    int b_wr, b_miss, s_rd, s_wr;

    RESET_N = 1'b0;
    tick(1);
    check_outputs_zero("reset");
    tick(1);
    RESET_N = 1'b1;
    tick(1);

    // Error-free stream with a 5-bit lead-in.
    clean_stream("clean", 4000);

    // Tolerable and intolerable errors in the first preamble.
    do_reset();
    b_wr = wr_cnt;
    push_bits(64'(PRE_2ERR), 30, 1'b0); push_bits(64'(PAY1), 48, 1'b1);
    wait_drain("err2", 2000);
    check("err2_writes", wr_cnt - b_wr, 48);
    check("err2_lock",   int'(SYNC_LOCK), 1);

    do_reset();
    b_wr = wr_cnt;
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'(PAY2), 48, 1'b0);
    wait_drain("err3", 2000);
    check("err3_writes", wr_cnt - b_wr, 0);
    check("err3_lock",   int'(SYNC_LOCK), 0);

    // Flywheel through two misses, then lose lock on three in a row.
    do_reset();
    b_wr = wr_cnt; b_miss = miss_cnt;
    push_bits(64'(PRE), 30, 1'b0);      push_bits(64'(PAY0), 48, 1'b1);
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'(PAY1), 48, 1'b1);
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'(PAY2), 48, 1'b1);
    push_bits(64'(PRE), 30, 1'b0);      push_bits(64'(PAY3), 48, 1'b1);
    wait_drain("fly", 4000);
    check("fly_writes", wr_cnt - b_wr, 192);
    check("fly_miss",   miss_cnt - b_miss, 2);
    check("fly_lock",   int'(SYNC_LOCK), 1);
    b_wr = wr_cnt;
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'(PAY0), 48, 1'b1);
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'(PAY1), 48, 1'b1);
    push_bits(64'(PRE_3ERR), 30, 1'b0); push_bits(64'd0, 48, 1'b0);
    wait_drain("loss", 4000);
    check("loss_writes", wr_cnt - b_wr, 96);
    check("loss_miss",   miss_cnt - b_miss, 5);
    check("loss_lock",   int'(SYNC_LOCK), 0);

    // Output back-pressure for 20 cycles mid-payload.
    do_reset();
    b_wr = wr_cnt;
    push_bits(64'(PRE), 30, 1'b0); push_bits(64'(PAY1), 48, 1'b1);
    wait_writes("bp_reach10", b_wr, 10);
    FIFO_OUT_FULL = 1'b1;
    tick(5);
    s_rd = rd_cnt; s_wr = wr_cnt;
    tick(15);
    check("bp_stall_re", rd_cnt - s_rd, 0);
    check("bp_stall_we", wr_cnt - s_wr, 0);
    FIFO_OUT_FULL = 1'b0;
    wait_drain("bp", 2000);
    check("bp_writes", wr_cnt - b_wr, 48);

    // Reset in the middle of a payload.
    do_reset();
    b_wr = wr_cnt;
    push_bits(64'(PRE), 30, 1'b0);
    for (int i = 0; i < 48; i++) begin
      in_q.push_back(PAY2[i]);
      if (i < 20) exp_q.push_back(PAY2[i]);
    end
    wait_writes("rst_reach20", b_wr, 20);
    RESET_N = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    tick(2);
    RESET_N = 1'b1;
    b_wr = wr_cnt;
    push_bits(64'(PRE), 30, 1'b0); push_bits(64'(PAY3), 48, 1'b1);
    wait_drain("rst_after", 3000);
    check("rst_after_writes", wr_cnt - b_wr, 48);
    check("rst_after_lock",   int'(SYNC_LOCK), 1);

    // Clean stream again with the input FIFO randomly starving.
    do_reset();
    starve = 1'b1;
    clean_stream("starve", 10000);
    starve = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
